// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: MUL shift-add (multiplier LSB first)
// or DIVU restoring step (one quotient bit, MSB first).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  mode_e              mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   op_b_next
);

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;

    always_comb begin
        acc_next   = acc;
        mcand_next = mcand;
        op_b_next  = op_b;
        rem        = acc[2*WIDTH-1:WIDTH];
        quo        = acc[WIDTH-1:0];
        partial    = {rem, quo[WIDTH-1]};
        trial      = partial - {1'b0, op_b};

        if (mode == MODE_MUL) begin
            if (op_b[0]) begin
                acc_next = acc + mcand;
            end
            mcand_next = mcand << 1;
            op_b_next  = op_b >> 1;
        end else begin
            // acc holds {remainder, dividend/quotient}; quotient bits shift in at the LSB
            if (trial[WIDTH]) begin
                acc_next = {partial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MUL / DIVU unit: IDLE -> BUSY -> DONE FSM around muldiv_step.
// Define MULDIV_EARLY_EXIT_EN to end MUL as soon as the remaining multiplier bits are zero.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic               mode,
    input  logic [WIDTH-1:0]   in_A,
    input  logic [WIDTH-1:0]   in_B,
    output logic               ready,
    output logic [2*WIDTH-1:0] out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               ready_q, ready_d;

    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] step_mcand;
    logic [WIDTH-1:0]   step_op_b;
    logic               busy_last;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode       (mode_q),
        .acc        (acc_q),
        .mcand      (mcand_q),
        .op_b       (op_b_q),
        .acc_next   (step_acc),
        .mcand_next (step_mcand),
        .op_b_next  (step_op_b)
    );

    always_comb begin
        busy_last = (cnt_q == CNT_LAST);
`ifdef MULDIV_EARLY_EXIT_EN
        // nothing left to add once the bits still to be shifted in are all zero
        if ((mode_q == MODE_MUL) && (op_b_q[WIDTH-1:1] == '0)) begin
            busy_last = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        op_b_d  = op_b_q;
        out_d   = out_q;
        ready_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    mode_d  = mode_e'(mode);
                    cnt_d   = '0;
                    acc_d   = (mode_e'(mode) == MODE_DIV) ? {{WIDTH{1'b0}}, in_A} : '0;
                    mcand_d = {{WIDTH{1'b0}}, in_A};
                    op_b_d  = in_B;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = step_acc;
                mcand_d = step_mcand;
                op_b_d  = step_op_b;
                cnt_d   = cnt_q + 1'b1;
                if (busy_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d   = acc_q;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            op_b_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            op_b_q  <= op_b_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with an arithmetic reference model checked every cycle.
module tb_mul_div_unit;

`ifdef MULDIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid = 1'b0;
    logic        mode  = 1'b0;
    logic [31:0] in_A  = '0;
    logic [31:0] in_B  = '0;
    logic        ready;
    logic [63:0] out;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mul_div_unit #(
        .WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (valid),
        .mode  (mode),
        .in_A  (in_A),
        .in_B  (in_B),
        .ready (ready),
        .out   (out)
    );

    function automatic logic [63:0] model_result(input logic m, input logic [31:0] a, input logic [31:0] b);
        if (!m) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    function automatic int model_latency(input logic m, input logic [31:0] b);
        int n;
        if (m || !EARLY) return 33;
        n = 0;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        if (n == 0) n = 1;
        return n + 1;
    endfunction

    // Reference model: edge count, pending result and its due edge.
    int          cyc        = 0;
    int          busy_until = 0;
    int          pend_edge  = 0;
    bit          pending    = 1'b0;
    logic [63:0] pend_out   = '0;
    logic [63:0] model_out  = '0;
    logic        exp_ready  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= 1'b0;
            busy_until <= 0;
            model_out  <= '0;
            exp_ready  <= 1'b0;
        end else begin
            cyc       <= cyc + 1;
            exp_ready <= 1'b0;
            if (pending && (cyc + 1 == pend_edge)) begin
                exp_ready <= 1'b1;
                model_out <= pend_out;
                pending   <= 1'b0;
            end
            if (valid && (cyc + 1 > busy_until)) begin
                pending    <= 1'b1;
                pend_edge  <= cyc + 1 + model_latency(mode, in_B);
                busy_until <= cyc + 1 + model_latency(mode, in_B);
                pend_out   <= model_result(mode, in_A, in_B);
            end
        end
    end

    always @(negedge clk) begin
        n_vec++;
        if (ready !== exp_ready) begin
            n_bad++;
            $display("FAIL monitor_ready t=%0t got %b want %b", $time, ready, exp_ready);
        end
        n_vec++;
        if (out !== model_out) begin
            n_bad++;
            $display("FAIL monitor_out t=%0t got %h want %h", $time, out, model_out);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] want, input int lat_early, input int lat_full,
                          input bit poke_busy);
        int  k;
        int  lat;
        int  extra;
        bit  seen;
        @(posedge clk); #1;
        valid = 1'b1; mode = m; in_A = a; in_B = b;
        @(posedge clk); #1;
        valid = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin
            if (poke_busy && k == 5) begin
                valid = 1'b1; mode = 1'b0; in_A = 32'h0000_DEAD; in_B = 32'd1;
            end
            if (poke_busy && k == 7) valid = 1'b0;
            @(posedge clk); #1;
            k++;
            if (ready) seen = 1'b1;
        end
        lat = EARLY ? lat_early : lat_full;
        check({name, "_latency"}, 64'(k), 64'(lat));
        check({name, "_out"}, out, want);
        if (poke_busy) begin
            extra = 0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (ready) extra++;
            end
            check({name, "_extra_ready"}, 64'(extra), 64'd0);
        end
        $display("op %s mode=%0d A=%h B=%h -> out=%h after %0d edges", name, m, a, b, out, k);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_out", out, 64'd0);
        rst_n = 1'b1;

        run_op("mul_7x6",   1'b0, 32'd7,           32'd6,           64'h0000_0000_0000_002A, 4,  33, 1'b0);
        run_op("mul_max",   1'b0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   64'hFFFF_FFFE_0000_0001, 33, 33, 1'b0);
        run_op("divu_100_7", 1'b1, 32'd100,        32'd7,           64'h0000_0002_0000_000E, 33, 33, 1'b0);
        run_op("divu_by0",  1'b1, 32'h0000_1234,   32'd0,           64'h0000_1234_FFFF_FFFF, 33, 33, 1'b0);

        // abort a MUL ten cycles into BUSY
        @(posedge clk); #1;
        valid = 1'b1; mode = 1'b0; in_A = 32'd5; in_B = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midop_reset_ready", 64'(ready), 64'd0);
        check("midop_reset_out", out, 64'd0);
        $display("op midop_reset -> ready=%b out=%h", ready, out);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_op("divu_9_2",  1'b1, 32'd9,           32'd2,           64'h0000_0001_0000_0004, 33, 33, 1'b1);
        run_op("mul_5x3",   1'b0, 32'd5,           32'd3,           64'h0000_0000_0000_000F, 3,  33, 1'b0);
        run_op("mul_5x0",   1'b0, 32'd5,           32'd0,           64'h0000_0000_0000_0000, 2,  33, 1'b0);
        run_op("divu_5_9",  1'b1, 32'd5,           32'd9,           64'h0000_0005_0000_0000, 33, 33, 1'b0);
        run_op("mul_hi",    1'b0, 32'h8000_0000,   32'h0000_0010,   64'h0000_0008_0000_0000, 6,  33, 1'b0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit instantiated inside CHIP, next to the ALU.
- Executes RV32M MUL and DIVU/REMU class operations for the single-cycle core.
- The core stalls PC/register writeback while the unit is busy.
- Results return to the core's writeback mux.

Parameters:
- WIDTH, 32, operand width; product/result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  start request; sampled only in IDLE.
- mode  input  1  0 = MUL (unsigned), 1 = DIVU.
- in_A  input  WIDTH  multiplicand / dividend.
- in_B  input  WIDTH  multiplier / divisor.
- ready  output  1  one-cycle pulse: out holds a fresh result.
- out  output  2*WIDTH  MUL: 64-bit product. DIV: {remainder, quotient} (remainder in upper half).

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; ready = 0; out = 0; counter = 0; operand registers = 0.
  - Applies immediately, including mid-operation; the aborted operation is lost, with no partial result.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - On a rising edge with valid=1: latch in_A, in_B and mode, clear counter and the accumulator/remainder, go to BUSY.
  - valid=0: stay in IDLE.
- BUSY: one iteration per clock; counter increments 0..WIDTH-1; on the edge where counter==WIDTH-1, go to DONE.
  - MUL: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle (LSB first).
  - DIVU: restoring division, one quotient bit per cycle (MSB first).
  - Trial subtract is WIDTH+1 bits wide; a negative result restores the remainder and sets quotient bit 0.
- DONE: ready=1 for exactly one cycle and out updated; next edge returns to IDLE.
- Latency: ready is high in the cycle starting WIDTH+1 rising edges after the accepting edge (33 for WIDTH=32). Back-to-back start is possible from the cycle after ready.
- valid asserted while in BUSY or DONE is ignored; the core must hold its request until ready.
- out holds the last result until the next DONE; it is not cleared on a new start.
- Divide by zero (in_B=0, mode=1): quotient = all ones, remainder = in_A; same latency, no exception.
- in_A < in_B (DIVU): quotient 0, remainder in_A.
- MUL width: a full 2*WIDTH product with no truncation; the core selects the low half for MUL and the high half for MULHU.

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined, MUL only: BUSY ends when the remaining unshifted multiplier bits are all zero.
  - BUSY length = max(1, index of highest set bit of in_B + 1) cycles.
  - DIVU is unchanged.
- Undefined: MUL always takes WIDTH BUSY cycles.
- Results are identical either way; only ready timing differs.

Decomposition:
- Package muldiv_pkg: state encoding (IDLE, BUSY, DONE), MODE_MUL=0 / MODE_DIV=1, WIDTH default, counter width = clog2(WIDTH).
- One combinational sub-module, muldiv_step, holds the per-iteration datapath:
  - MUL add-and-shift.
  - DIVU trial subtract, restore and quotient-bit insert.
- The top level keeps the FSM, counter and registers.

Test Plan:
- MUL 7 x 6: valid for one cycle -> ready exactly 33 edges after accept, out=64'h0000_0000_0000_002A.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> out=64'hFFFF_FFFE_0000_0001.
- DIVU 100 / 7 -> out=64'h0000_0002_0000_000E.
- DIVU 0x1234 / 0 -> out=64'h0000_1234_FFFF_FFFF.
- Reset mid-operation and ignored re-request:
  - Start MUL 5 x 3, pull rst_n low at BUSY cycle 10 -> ready=0 and out=0 immediately.
  - Then release reset and run DIVU 9 / 2 -> out=64'h0000_0001_0000_0004.
  - valid pulsed during BUSY -> no extra ready pulse.
- Early exit:
  - With MULDIV_EARLY_EXIT_EN, MUL 5 x 3 -> ready 3 edges after accept, out=15.
  - MUL 5 x 0 -> ready 2 edges after accept, out=0.
  - Without the macro, both take 33 edges.
